// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - Rijndael ShiftRows / InvShiftRows with a valid/ready register pipeline
//
// Purpose: permutes a 32*NB-bit Rijndael state (forward or inverse ShiftRows,
// selected per word) and carries it through LAT elastic register stages.
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - upstream word offered
//   in_ready   - pipeline can accept this cycle
//   in_mode    - 0 forward ShiftRows, 1 inverse ShiftRows
//   in_data    - state, byte k = row k%4, column k/4, byte 0 in MSBs
//   out_valid  - result offered
//   out_ready  - downstream accepts
//   out_mode   - in_mode carried with the word
//   out_data   - permuted state
//   occupancy  - number of valid stages, 0..LAT
module shift_rows_pipe #(
  parameter int NB  = 4,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [32*NB-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_mode,
  output logic [32*NB-1:0] out_data,
  output logic [2:0]      occupancy
);

  localparam int W = 32 * NB;

  logic [W-1:0]   w_fwd;
  logic [W-1:0]   w_inv;
  logic [W-1:0]   w_perm;
  logic [LAT-1:0] w_load;
  logic           w_in_fire;
  logic           w_out_fire;

  logic [LAT-1:0] r_valid;
  logic [LAT-1:0] r_mode;
  logic [W-1:0]   r_data [LAT];
  logic [2:0]     r_occ;

  // Pure wiring: every destination byte picks a fixed source byte in the same row.
  // The 256-bit state skips one extra column on rows 2 and 3.
  genvar gr, gc;
  generate
    for (gr = 0; gr < 4; gr++) begin : g_row
      localparam int OFF = (NB == 8 && gr >= 2) ? gr + 1 : gr;
      for (gc = 0; gc < NB; gc++) begin : g_col
        localparam int DST  = W - 1 - 8 * (4 * gc + gr);
        localparam int FSRC = W - 1 - 8 * (4 * ((gc + OFF) % NB) + gr);
        localparam int ISRC = W - 1 - 8 * (4 * ((gc + NB - OFF) % NB) + gr);
        assign w_fwd[DST -: 8] = in_data[FSRC -: 8];
        assign w_inv[DST -: 8] = in_data[ISRC -: 8];
      end
    end
  endgenerate

  assign w_perm = in_mode ? w_inv : w_fwd;

  // A stage may load if downstream drains or any stage from here to the output
  // is a bubble; written in closed form so no load term depends on another.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_load
      assign w_load[gi] = out_ready | ~(&r_valid[LAT-1:gi]);
    end
  endgenerate

  assign in_ready   = w_load[0];
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_mode  <= '0;
      r_occ   <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_perm;
          r_mode[0] <= in_mode;
        end
      end
      // Bubbles move forward as valid=0 only; payload keeps its last value.
      for (int i = 1; i < LAT; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_data[i] <= r_data[i-1];
            r_mode[i] <= r_mode[i-1];
          end
        end
      end
      if (w_in_fire && !w_out_fire) begin
        r_occ <= r_occ + 3'd1;
      end else if (!w_in_fire && w_out_fire) begin
        r_occ <= r_occ - 3'd1;
      end
    end
  end

  assign out_valid = r_valid[LAT-1];
  assign out_mode  = r_mode[LAT-1];
  assign out_data  = r_data[LAT-1];
  assign occupancy = r_occ;

endmodule
